// File: rtl/lcd_pkg.sv
// Shared types, command constants and default bus timing for the HD44780 sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [6:0] CMD_HOME_MASK = 7'b0000001;

    // Defaults assume a 50 MHz clock.
    localparam int DEF_T_AS   = 3;
    localparam int DEF_T_PW   = 13;
    localparam int DEF_T_H    = 3;
    localparam int DEF_T_EXEC = 2000;
    localparam int DEF_T_SLOW = 82000;
    localparam int DEF_DEPTH  = 4;

    // Clear Display (0x01) and Return Home (0x02/0x03) need the long execution delay.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME_MASK));
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO holding {rs, data} requests ahead of the bus sequencer.
module lcd_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage needs no reset; it is only read while non-empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Hardware-timed HD44780 write cycles: FIFO-buffered {RS, byte} requests become
// setup / E-pulse / hold / execution-delay sequences on the LCD bus.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int T_AS   = DEF_T_AS,
    parameter int T_PW   = DEF_T_PW,
    parameter int T_H    = DEF_T_H,
    parameter int T_EXEC = DEF_T_EXEC,
    parameter int T_SLOW = DEF_T_SLOW,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_rs,
    input  logic [7:0]              in_data,
    output logic                    lcd_e,
    output logic                    lcd_rs,
    output logic [7:0]              lcd_data,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level
);

    // Counter is sized for the longest interval it ever holds.
    localparam int T_MAX = (T_SLOW > T_EXEC) ? T_SLOW : T_EXEC;
    localparam int CW    = $clog2(T_MAX + 1);

    lcd_state_t  r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic        r_e, w_e_nxt;
    logic        r_rs, w_rs_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [8:0]  w_head;

    lcd_cmd_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (in_valid),
        .i_data  ({in_rs, in_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign in_ready = !w_full;
    assign busy     = (level != '0) || (r_state != IDLE);
    assign lcd_e    = r_e;
    assign lcd_rs   = r_rs;
    assign lcd_data = r_data;

    // State, interval counter and registered bus outputs; reset drops E at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_e     <= w_e_nxt;
            r_rs    <= w_rs_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // Next-state logic: each phase counts down its interval, then loads the next one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_e_nxt     = r_e;
        w_rs_nxt    = r_rs;
        w_data_nxt  = r_data;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_e_nxt = 1'b0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_rs_nxt    = w_head[8];
                    w_data_nxt  = w_head[7:0];
                    w_cnt_nxt   = CW'(T_AS - 1);
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_e_nxt     = 1'b1;
                    w_cnt_nxt   = CW'(T_PW - 1);
                    w_state_nxt = PULSE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    w_e_nxt     = 1'b0;
                    w_cnt_nxt   = CW'(T_H - 1);
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = is_slow_cmd(r_rs, r_data) ? CW'(T_SLOW - 1) : CW'(T_EXEC - 1);
                    w_state_nxt = WAIT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Randomized bench for lcd_bus_sequencer: two instances (scaled timing, minimum
// timing) share stimulus and are checked every cycle against a timeline model.
module tb_lcd_bus_sequencer;

    localparam int A_AS = 3, A_PW = 13, A_H = 3, A_EXEC = 60, A_SLOW = 300;
    localparam int B_AS = 1, B_PW = 1,  B_H = 1, B_EXEC = 1,  B_SLOW = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       rdy0, e0, rs0, bsy0;
    logic [7:0] db0;
    logic [2:0] lvl0;
    logic       rdy1, e1, rs1, bsy1;
    logic [7:0] db1;
    logic [2:0] lvl1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lcd_bus_sequencer #(.T_AS(A_AS), .T_PW(A_PW), .T_H(A_H), .T_EXEC(A_EXEC),
                        .T_SLOW(A_SLOW), .DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_rs(in_rs), .in_data(in_data), .lcd_e(e0), .lcd_rs(rs0),
        .lcd_data(db0), .busy(bsy0), .level(lvl0));

    lcd_bus_sequencer #(.T_AS(B_AS), .T_PW(B_PW), .T_H(B_H), .T_EXEC(B_EXEC),
                        .T_SLOW(B_SLOW), .DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_rs(in_rs), .in_data(in_data), .lcd_e(e1), .lcd_rs(rs1),
        .lcd_data(db1), .busy(bsy1), .level(lvl1));

    // ---------------- reference model: timeline of bus cycles ----------------
    int       n = 0;              // count of clock edges seen out of reset
    logic [8:0] mbuf [2][8];
    int       mhd [2];
    int       mcnt [2];
    logic     mhas [2];
    logic [8:0] mcur [2];
    int       mstart [2];
    int       mfree [2];          // first edge at which the next entry may start
    logic     macc [2];

    function automatic int p_as(int d);   return d == 0 ? A_AS : B_AS;     endfunction
    function automatic int p_pw(int d);   return d == 0 ? A_PW : B_PW;     endfunction
    function automatic int p_h(int d);    return d == 0 ? A_H : B_H;       endfunction
    function automatic int p_exec(int d); return d == 0 ? A_EXEC : B_EXEC; endfunction
    function automatic int p_slow(int d); return d == 0 ? A_SLOW : B_SLOW; endfunction

    function automatic logic slow_entry(logic [8:0] x);
        return (x[8] == 1'b0) && (x[7:0] == 8'h01 || x[7:0] == 8'h02 || x[7:0] == 8'h03);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mhd[d] = 0; mcnt[d] = 0; mhas[d] = 1'b0; mcur[d] = 9'h000;
            mstart[d] = 0; mfree[d] = 0; macc[d] = 1'b0;
        end
    endtask

    task automatic model_step();
        n++;
        for (int d = 0; d < 2; d++) begin
            int sz;
            sz = mcnt[d];
            macc[d] = in_valid && (sz < DEPTH);
            if (sz > 0 && n >= mfree[d]) begin
                mcur[d] = mbuf[d][mhd[d]];
                mhd[d] = (mhd[d] + 1) % 8;
                mcnt[d]--;
                mhas[d] = 1'b1;
                mstart[d] = n;
                mfree[d] = n + p_as(d) + p_pw(d) + p_h(d) + 1 +
                           (slow_entry(mcur[d]) ? p_slow(d) : p_exec(d));
            end
            if (macc[d]) begin
                mbuf[d][(mhd[d] + mcnt[d]) % 8] = {in_rs, in_data};
                mcnt[d]++;
            end
        end
    endtask

    function automatic logic exp_e(int d);
        return mhas[d] && (n >= mstart[d] + p_as(d)) && (n < mstart[d] + p_as(d) + p_pw(d));
    endfunction

    function automatic logic exp_busy(int d);
        return (mcnt[d] != 0) || (mhas[d] && n < mfree[d] - 1);
    endfunction

    function automatic logic model_idle(int d);
        return !exp_busy(d);
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @edge%0d: got 0x%0h, want 0x%0h", tag, n, obs, exp);
        end
    endtask

    task automatic cmp_dut(input int d, input logic e, input logic rs, input logic [7:0] db,
                           input logic [2:0] lvl, input logic rdy, input logic bsy);
        string p;
        p = (d == 0) ? "d0" : "d1";
        chk({p, "_e"},     32'(e),   32'(exp_e(d)));
        chk({p, "_rs"},    32'(rs),  32'(mhas[d] ? mcur[d][8] : 1'b0));
        chk({p, "_db"},    32'(db),  32'(mhas[d] ? mcur[d][7:0] : 8'h00));
        chk({p, "_level"}, 32'(lvl), 32'(mcnt[d]));
        chk({p, "_ready"}, 32'(rdy), 32'(mcnt[d] < DEPTH));
        chk({p, "_busy"},  32'(bsy), 32'(exp_busy(d)));
    endtask

    task automatic compare_all();
        cmp_dut(0, e0, rs0, db0, lvl0, rdy0, bsy0);
        cmp_dut(1, e1, rs1, db1, lvl1, rdy1, bsy1);
    endtask

    int e0_rises = 0;
    logic e0_prev = 1'b0;

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        #1;
        if (e0 && !e0_prev) e0_rises++;
        e0_prev = e0;
        compare_all();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (!(model_idle(0) && model_idle(1)) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) chk("drain_timeout", 0, 1);
    endtask

    task automatic push1(input logic rs, input logic [7:0] d);
        in_valid = 1'b1; in_rs = rs; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    logic [8:0] burst [6];

    initial begin
        model_reset();
        // Reset asserted from time zero: everything idle and empty.
        #1;
        compare_all();
        repeat (3) tick();
        reset = 1'b1;
        repeat (5) tick();

        // Reset in the middle of an E pulse.
        push1(1'b0, 8'h38);
        begin
            int k;
            k = 0;
            while (!exp_e(0) && k < 100) begin tick(); k++; end
            if (k >= 100) chk("e_rise_timeout", 0, 1);
        end
        repeat (4) tick();
        chk("e_high_before_rst", 32'(e0), 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (3) tick();
        reset = 1'b1;
        repeat (40) tick();
        chk("no_pulse_after_rst", 32'(e0_rises), 1);

        // Single data write.
        push1(1'b1, 8'h41);
        drain(1000);

        // Slow-command detection: Clear, Home, then entry mode set.
        push1(1'b0, 8'h01);
        push1(1'b0, 8'h02);
        push1(1'b0, 8'h06);
        drain(3000);

        // Backpressure: six requests with in_valid held until each is accepted.
        burst[0] = 9'h130; burst[1] = 9'h131; burst[2] = 9'h0C0;
        burst[3] = 9'h132; burst[4] = 9'h000; burst[5] = 9'h133;
        e0_rises = 0;
        begin
            int idx, k;
            idx = 0; k = 0;
            in_valid = 1'b1;
            while (idx < 6 && k < 3000) begin
                in_rs = burst[idx][8];
                in_data = burst[idx][7:0];
                tick();
                if (macc[0]) idx++;
                k++;
            end
            in_valid = 1'b0;
            if (k >= 3000) chk("burst_timeout", 0, 1);
        end
        drain(3000);
        chk("burst_pulses", 32'(e0_rises), 6);

        // Randomized traffic, biased toward slow commands and zero bytes.
        for (int c = 0; c < 2500; c++) begin
            in_valid = ($urandom_range(0, 9) < 3);
            in_rs = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: in_data = 8'($urandom_range(0, 3));
                default: in_data = 8'($urandom);
            endcase
            tick();
        end
        in_valid = 1'b0;
        drain(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
